segment_id_ex_stage: RTL and testbench



---
 rtl/segment_id_ex_stage.sv | 108 ++++++++++
 tb/tb_segment_id_ex_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/segment_id_ex_stage.sv
// ID/EX pipeline register: captures decode-stage controls, operands, address and immediate.
// One cycle latency, no stall/flush; async active-low reset clears every field to zero.
module segment_id_ex_stage #(
   parameter int DATA_W     = 21,
   parameter int REG_ADDR_W = 4,
   parameter int ALUOP_W    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  MemToReg_in,
   input  logic                  MemRead_in,
   input  logic                  MemWrite_in,
   input  logic [ALUOP_W-1:0]    ALUOp_in,
   input  logic                  ALUSrc_in,
   input  logic                  RegWrite_in,
   input  logic [DATA_W-1:0]     pc_in,
   input  logic [DATA_W-1:0]     RD1_in,
   input  logic [DATA_W-1:0]     RD2_in,
   input  logic [DATA_W-1:0]     RD3_in,
   input  logic [REG_ADDR_W-1:0] RR3_in,
   input  logic [DATA_W-1:0]     num_in,
   output logic                  MemToReg_out,
   output logic                  MemRead_out,
   output logic                  MemWrite_out,
   output logic [ALUOP_W-1:0]    ALUOp_out,
   output logic                  ALUSrc_out,
   output logic                  RegWrite_out,
   output logic [DATA_W-1:0]     pc_out,
   output logic [DATA_W-1:0]     RD1_out,
   output logic [DATA_W-1:0]     RD2_out,
   output logic [DATA_W-1:0]     RD3_out,
   output logic [REG_ADDR_W-1:0] RR3_out,
   output logic [DATA_W-1:0]     num_out
);

   logic                  mem_to_reg_d, mem_to_reg_q;
   logic                  mem_read_d,   mem_read_q;
   logic                  mem_write_d,  mem_write_q;
   logic [ALUOP_W-1:0]    alu_op_d,     alu_op_q;
   logic                  alu_src_d,    alu_src_q;
   logic                  reg_write_d,  reg_write_q;
   logic [DATA_W-1:0]     pc_d,         pc_q;
   logic [DATA_W-1:0]     rd1_d,        rd1_q;
   logic [DATA_W-1:0]     rd2_d,        rd2_q;
   logic [DATA_W-1:0]     rd3_d,        rd3_q;
   logic [REG_ADDR_W-1:0] rr3_d,        rr3_q;
   logic [DATA_W-1:0]     num_d,        num_q;

   // Pure pass-through: every edge loads the decode-stage values unchanged.
   always_comb begin
      mem_to_reg_d = MemToReg_in;
      mem_read_d   = MemRead_in;
      mem_write_d  = MemWrite_in;
      alu_op_d     = ALUOp_in;
      alu_src_d    = ALUSrc_in;
      reg_write_d  = RegWrite_in;
      pc_d         = pc_in;
      rd1_d        = RD1_in;
      rd2_d        = RD2_in;
      rd3_d        = RD3_in;
      rr3_d        = RR3_in;
      num_d        = num_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_to_reg_q <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         alu_op_q     <= '0;
         alu_src_q    <= 1'b0;
         reg_write_q  <= 1'b0;
         pc_q         <= '0;
         rd1_q        <= '0;
         rd2_q        <= '0;
         rd3_q        <= '0;
         rr3_q        <= '0;
         num_q        <= '0;
      end else begin
         mem_to_reg_q <= mem_to_reg_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         alu_op_q     <= alu_op_d;
         alu_src_q    <= alu_src_d;
         reg_write_q  <= reg_write_d;
         pc_q         <= pc_d;
         rd1_q        <= rd1_d;
         rd2_q        <= rd2_d;
         rd3_q        <= rd3_d;
         rr3_q        <= rr3_d;
         num_q        <= num_d;
      end
   end

   assign MemToReg_out = mem_to_reg_q;
   assign MemRead_out  = mem_read_q;
   assign MemWrite_out = mem_write_q;
   assign ALUOp_out    = alu_op_q;
   assign ALUSrc_out   = alu_src_q;
   assign RegWrite_out = reg_write_q;
   assign pc_out       = pc_q;
   assign RD1_out      = rd1_q;
   assign RD2_out      = rd2_q;
   assign RD3_out      = rd3_q;
   assign RR3_out      = rr3_q;
   assign num_out      = num_q;

endmodule

// File: tb/tb_segment_id_ex_stage.sv
// Bench for the ID/EX register: directed steps plus random traffic against a last-captured-value model.
module tb_segment_id_ex_stage;

   typedef struct packed {
      logic        m2r;
      logic        mr;
      logic        mw;
      logic [2:0]  aluop;
      logic        alusrc;
      logic        rw;
      logic [20:0] pc;
      logic [20:0] rd1;
      logic [20:0] rd2;
      logic [20:0] rd3;
      logic [3:0]  rr3;
      logic [20:0] num;
   } bundle_t;

   logic    clk = 1'b0;
   logic    rst = 1'b0;
   bundle_t in_s = '0;
   bundle_t out_s;
   bundle_t model = '0;
   int      checks = 0;
   int      errors = 0;

   always #5 clk = ~clk;

   segment_id_ex_stage #(.DATA_W(21), .REG_ADDR_W(4), .ALUOP_W(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .MemToReg_in  (in_s.m2r),
      .MemRead_in   (in_s.mr),
      .MemWrite_in  (in_s.mw),
      .ALUOp_in     (in_s.aluop),
      .ALUSrc_in    (in_s.alusrc),
      .RegWrite_in  (in_s.rw),
      .pc_in        (in_s.pc),
      .RD1_in       (in_s.rd1),
      .RD2_in       (in_s.rd2),
      .RD3_in       (in_s.rd3),
      .RR3_in       (in_s.rr3),
      .num_in       (in_s.num),
      .MemToReg_out (out_s.m2r),
      .MemRead_out  (out_s.mr),
      .MemWrite_out (out_s.mw),
      .ALUOp_out    (out_s.aluop),
      .ALUSrc_out   (out_s.alusrc),
      .RegWrite_out (out_s.rw),
      .pc_out       (out_s.pc),
      .RD1_out      (out_s.rd1),
      .RD2_out      (out_s.rd2),
      .RD3_out      (out_s.rd3),
      .RR3_out      (out_s.rr3),
      .num_out      (out_s.num)
   );

   function automatic bundle_t rand_bundle();
      bundle_t b;
      b.m2r    = 1'($urandom);
      b.mr     = 1'($urandom);
      b.mw     = 1'($urandom);
      b.aluop  = 3'($urandom);
      b.alusrc = 1'($urandom);
      b.rw     = 1'($urandom);
      b.pc     = 21'($urandom);
      b.rd1    = 21'($urandom);
      b.rd2    = 21'($urandom);
      b.rd3    = 21'($urandom);
      b.rr3    = 4'($urandom);
      b.num    = 21'($urandom);
      return b;
   endfunction

   task automatic check(input string tag, input bundle_t exp);
      checks++;
      assert (out_s === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, out_s, exp);
      end
   endtask

   // Drive v before the next rising edge, update the model the way the stage
   // should behave, then check right after the edge and again after a
   // mid-cycle input disturbance.
   task automatic step(input string tag, input bundle_t v);
      @(negedge clk);
      in_s = v;
      @(posedge clk);
      if (rst) model = v;
      #1;
      check({tag, "_post_edge"}, model);
      #2;
      in_s = rand_bundle();
      #1;
      check({tag, "_mid_cycle"}, model);
   endtask

   initial begin
      bundle_t v;

      // Power-up in reset with zero inputs.
      repeat (2) @(posedge clk);
      #1;
      check("powerup_zero", '0);

      // Non-zero inputs while reset held: no capture, including edges with rst=0.
      for (int i = 0; i < 3; i++) step("reset_hold", rand_bundle());

      @(negedge clk);
      rst = 1'b1;
      #1;
      check("release_still_zero", '0);

      v = '0;
      v.m2r = 1'b1; v.mr = 1'b1; v.mw = 1'b0; v.aluop = 3'b101;
      v.alusrc = 1'b1; v.rw = 1'b1; v.pc = 21'd100; v.rd1 = 21'd200;
      v.rd2 = 21'd300; v.rd3 = 21'd400; v.rr3 = 4'd5; v.num = 21'd500;
      step("capture", v);

      v.mw = 1'b1; v.aluop = 3'b010; v.pc = 21'd600; v.rd1 = 21'd700;
      v.rd2 = 21'd800; v.rd3 = 21'd900; v.rr3 = 4'd6; v.num = 21'd1000;
      step("update", v);

      // Asynchronous reset midway between edges.
      @(negedge clk);
      rst = 1'b0;
      model = '0;
      #1;
      check("async_reset_immediate", '0);
      @(posedge clk);
      #1;
      check("async_reset_held_over_edge", '0);
      @(negedge clk);
      rst = 1'b1;

      v.aluop = 3'b111; v.pc = 21'h1FFFFF; v.rd1 = 21'h1FFFFF;
      v.rd2 = 21'h1FFFFF; v.rd3 = 21'h1FFFFF; v.rr3 = 4'hF; v.num = 21'h1FFFFF;
      step("width_extremes", v);

      // Random traffic with occasional mid-cycle reset pulses.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            @(negedge clk);
            rst = 1'b0;
            model = '0;
            #1;
            check("rand_async_reset", '0);
            if ($urandom_range(0, 1) == 1) step("rand_in_reset", rand_bundle());
            @(negedge clk);
            rst = 1'b1;
         end
         step("random", rand_bundle());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
